move_controller: RTL and testbench

//   Issues the pick/place command stream that the board-state register consumes. It turns mouse

---
 rtl/chess_pkg.sv | 36 +++
 rtl/move_controller_click_edge.sv | 27 ++
 rtl/move_controller.sv | 182 ++++++++++++++++++
 tb/tb_move_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, side tests and the move-controller FSM states.
package chess_pkg;

  localparam logic [3:0] EMPTY     = 4'h0;
  localparam logic [3:0] W_PAWN    = 4'h1;
  localparam logic [3:0] W_KNIGHT  = 4'h2;
  localparam logic [3:0] W_BISHOP  = 4'h3;
  localparam logic [3:0] W_ROOK    = 4'h4;
  localparam logic [3:0] W_QUEEN   = 4'h5;
  localparam logic [3:0] W_KING    = 4'h6;
  localparam logic [3:0] B_PAWN    = 4'h7;
  localparam logic [3:0] B_KNIGHT  = 4'h8;
  localparam logic [3:0] B_BISHOP  = 4'h9;
  localparam logic [3:0] B_ROOK    = 4'hA;
  localparam logic [3:0] B_QUEEN   = 4'hB;
  localparam logic [3:0] B_KING    = 4'hC;
  localparam logic [3:0] MOVE_MARK = 4'hD;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QUERY  = 3'd1,
    CHECK  = 3'd2,
    SETTLE = 3'd3,
    HELD   = 3'd4,
    OVER   = 3'd5
  } state_t;

  function automatic logic is_white(input logic [3:0] code);
    return (code >= W_PAWN) && (code <= W_KING);
  endfunction

  function automatic logic is_black(input logic [3:0] code);
    return (code >= B_PAWN) && (code <= B_KING);
  endfunction

endpackage

// File: rtl/move_controller_click_edge.sv
// Two-flop synchroniser for the raw mouse button plus a one-cycle rising-edge pulse.
module click_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_level;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/move_controller.sv
// Turns square clicks into pick/place pulses for the board register, enforcing turn order.
// Optional per-turn timeout enabled by defining TURN_TIMER_EN (adds port timeout_loss).
import chess_pkg::*;

module move_controller #(
  parameter int MOVES_LAT = 2
`ifdef TURN_TIMER_EN
  , parameter int TURN_CYCLES = 65_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        click,
  input  logic [5:0]  cursor_pos,
  input  logic [3:0]  query_code,
  input  logic [63:0] possible_moves,
  input  logic        white_win,
  input  logic        black_win,
  output logic [5:0]  query_xy,
  output logic [5:0]  figure_position,
  output logic        pick_piece,
  output logic        place_piece,
  output logic [5:0]  pp_from,
  output logic        piece_held,
  output logic        turn_white,
  output logic        game_over,
`ifdef TURN_TIMER_EN
  output logic        timeout_loss,
`endif
  output state_t      dbg_state
);

  localparam logic [7:0] SETTLE_LAST = 8'(MOVES_LAT - 1);

  logic       w_click;
  logic       w_win;
  logic       w_win_rise;
  logic       w_side_ok;

  state_t     r_state;
  logic [5:0] r_query_xy;
  logic [5:0] r_fig;
  logic       r_pick;
  logic       r_place;
  logic [5:0] r_pp_from;
  logic       r_held;
  logic       r_turn_white;
  logic       r_game_over;
  logic       r_win_prev;
  logic [7:0] r_settle_cnt;

`ifdef TURN_TIMER_EN
  localparam logic [26:0] TIMER_LAST = 27'(TURN_CYCLES - 1);
  logic [26:0] r_timer;
  logic        r_timeout_pend;
  logic        r_timeout_loss;
  logic        w_timeout;
  assign w_timeout    = (r_timer == TIMER_LAST) && !r_game_over && !r_timeout_pend;
  assign timeout_loss = r_timeout_loss;
`endif

  click_edge u_click_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (click),
    .o_pulse (w_click)
  );

  assign w_win      = white_win | black_win;
  assign w_win_rise = w_win & ~r_win_prev;
  assign w_side_ok  = r_turn_white ? is_white(query_code) : is_black(query_code);

  // Pulses default low every cycle; a win rise overrides any action in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_query_xy   <= '0;
      r_fig        <= '0;
      r_pick       <= 1'b0;
      r_place      <= 1'b0;
      r_pp_from    <= '0;
      r_held       <= 1'b0;
      r_turn_white <= 1'b1;
      r_game_over  <= 1'b0;
      r_win_prev   <= 1'b0;
      r_settle_cnt <= '0;
`ifdef TURN_TIMER_EN
      r_timer        <= '0;
      r_timeout_pend <= 1'b0;
      r_timeout_loss <= 1'b0;
`endif
    end else begin
      r_pick     <= 1'b0;
      r_place    <= 1'b0;
      r_win_prev <= w_win;
`ifdef TURN_TIMER_EN
      if (!r_game_over) r_timer <= r_timer + 27'd1;
`endif
      if (w_win_rise) begin
        r_state     <= OVER;
        r_game_over <= 1'b1;
      end
`ifdef TURN_TIMER_EN
      else if (r_timeout_pend) begin
        r_state        <= OVER;
        r_game_over    <= 1'b1;
        r_timeout_pend <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_loss <= r_turn_white;
        if (r_held) begin
          r_place        <= 1'b1;
          r_fig          <= r_pp_from;
          r_held         <= 1'b0;
          r_timeout_pend <= 1'b1;
        end else begin
          r_state     <= OVER;
          r_game_over <= 1'b1;
        end
      end
`endif
      else begin
        case (r_state)
          IDLE: begin
            if (w_click) begin
              r_query_xy <= cursor_pos;
              r_state    <= QUERY;
            end
          end
          QUERY: r_state <= CHECK;
          CHECK: begin
            if (w_side_ok) begin
              r_fig        <= r_query_xy;
              r_pp_from    <= r_query_xy;
              r_pick       <= 1'b1;
              r_held       <= 1'b1;
              r_settle_cnt <= '0;
              r_state      <= SETTLE;
            end else begin
              r_state <= IDLE;
            end
          end
          SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) r_state <= HELD;
            else r_settle_cnt <= r_settle_cnt + 8'd1;
          end
          HELD: begin
            if (w_click) begin
              if (cursor_pos == r_pp_from) begin
                r_place <= 1'b1;
                r_fig   <= r_pp_from;
                r_held  <= 1'b0;
                r_state <= IDLE;
              end else if (possible_moves[cursor_pos]) begin
                r_place      <= 1'b1;
                r_fig        <= cursor_pos;
                r_held       <= 1'b0;
                r_turn_white <= ~r_turn_white;
                r_state      <= IDLE;
`ifdef TURN_TIMER_EN
                r_timer      <= '0;
`endif
              end
            end
          end
          OVER:    r_state <= OVER;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign query_xy        = r_query_xy;
  assign figure_position = r_fig;
  assign pick_piece      = r_pick;
  assign place_piece     = r_place;
  assign pp_from         = r_pp_from;
  assign piece_held      = r_held;
  assign turn_white      = r_turn_white;
  assign game_over       = r_game_over;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed vector table, hand sequences and a random click stream.
module tb_move_controller;
  import chess_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        click = 1'b0;
  logic [5:0]  cursor_pos = '0;
  logic [3:0]  query_code;
  logic [63:0] possible_moves = '0;
  logic        white_win = 1'b0;
  logic        black_win = 1'b0;
  logic [5:0]  query_xy;
  logic [5:0]  figure_position;
  logic        pick_piece;
  logic        place_piece;
  logic [5:0]  pp_from;
  logic        piece_held;
  logic        turn_white;
  logic        game_over;
  state_t      dbg_state;
`ifdef TURN_TIMER_EN
  logic        timeout_loss;
`endif

  move_controller #(
    .MOVES_LAT (2)
`ifdef TURN_TIMER_EN
    , .TURN_CYCLES (100)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .click           (click),
    .cursor_pos      (cursor_pos),
    .query_code      (query_code),
    .possible_moves  (possible_moves),
    .white_win       (white_win),
    .black_win       (black_win),
    .query_xy        (query_xy),
    .figure_position (figure_position),
    .pick_piece      (pick_piece),
    .place_piece     (place_piece),
    .pp_from         (pp_from),
    .piece_held      (piece_held),
    .turn_white      (turn_white),
    .game_over       (game_over),
`ifdef TURN_TIMER_EN
    .timeout_loss    (timeout_loss),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / board model ----------------
  always #5 clk = ~clk;

  logic [3:0] board [64];
  always @(posedge clk) query_code <= board[query_xy];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];   // {is_place, square}
  logic [6:0] obs_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (pick_piece || place_piece) begin
        checks++;
        if (pick_piece && place_piece) begin
          errors++;
          $display("FAIL both_pulses: pick=%0b place=%0b, required not both high", pick_piece, place_piece);
        end
      end
      if (pick_piece)  obs_q.push_back({1'b0, figure_position});
      if (place_piece) obs_q.push_back({1'b1, figure_position});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_events(input string name);
    logic [6:0] e, o;
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({name, "_event"}, 64'(o), 64'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- reference model ----------------
  bit         m_turn;
  bit         m_held;
  logic [5:0] m_from;

  function automatic bit own_piece(input logic [3:0] code, input bit white);
    if (white) return (code >= 4'd1) && (code <= 4'd6);
    return (code >= 4'd7) && (code <= 4'd12);
  endfunction

  task automatic model_click(input logic [5:0] sq);
    if (!m_held) begin
      if (own_piece(board[sq], m_turn)) begin
        exp_q.push_back({1'b0, sq});
        m_held = 1'b1;
        m_from = sq;
      end
    end else if (sq == m_from) begin
      exp_q.push_back({1'b1, sq});
      m_held = 1'b0;
    end else if (possible_moves[sq]) begin
      exp_q.push_back({1'b1, sq});
      m_held = 1'b0;
      m_turn = ~m_turn;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic reset_dut();
    rst_n = 1'b0;
    click = 1'b0;
    white_win = 1'b0;
    black_win = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    m_turn = 1'b1;
    m_held = 1'b0;
    m_from = '0;
  endtask

  task automatic do_click(input logic [5:0] sq);
    cursor_pos = sq;
    @(negedge clk);
    click = 1'b1;
    repeat (3) @(negedge clk);
    click = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0] sq;
    logic [1:0] kind;   // 0 none, 1 pick, 2 place
    logic [5:0] pos;
    logic       turn;
    logic       held;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit found;
    logic [5:0] sq;

    for (int i = 0; i < 64; i++) board[i] = EMPTY;
    board[52] = W_PAWN;
    board[12] = B_PAWN;
    board[11] = B_KNIGHT;
    board[62] = W_KNIGHT;
    possible_moves = 64'h0000_0010_1000_0000;   // squares 28 and 36

    reset_dut();
    check("rst_turn_white", 64'(turn_white), 64'd1);
    check("rst_pick", 64'(pick_piece), 64'd0);
    check("rst_place", 64'(place_piece), 64'd0);
    check("rst_game_over", 64'(game_over), 64'd0);
    check("rst_piece_held", 64'(piece_held), 64'd0);
    check("rst_fig_pos", 64'(figure_position), 64'd0);
    check("rst_pp_from", 64'(pp_from), 64'd0);
    check("rst_query_xy", 64'(query_xy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef TURN_TIMER_EN
    check("rst_timeout_loss", 64'(timeout_loss), 64'd0);

    // Pick at 62 then stay silent until the per-turn limit expires.
    do_click(62);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (place_piece) found = 1'b1;
    end
    check("timeout_place_seen", 64'(found), 64'd1);
    @(negedge clk);
    exp_q.push_back({1'b0, 6'd62});
    exp_q.push_back({1'b1, 6'd62});
    compare_events("timeout");
    check("timeout_game_over", 64'(game_over), 64'd1);
    check("timeout_loss_white", 64'(timeout_loss), 64'd1);
    check("timeout_held", 64'(piece_held), 64'd0);
    check("timeout_state", 64'(dbg_state), 64'(OVER));
`else
    // Latency: two synchroniser flops, then IDLE->QUERY->CHECK->pick.
    cursor_pos = 6'd52;
    @(negedge clk);
    click = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (pick_piece) found = 1'b1;
    end
    check("pick_latency", 64'(lat), 64'd5);
    check("pick_fig_pos", 64'(figure_position), 64'd52);
    @(negedge clk);
    check("pick_one_cycle", 64'(pick_piece), 64'd0);
    click = 1'b0;
    repeat (12) @(negedge clk);
    exp_q.push_back({1'b0, 6'd52});
    compare_events("latency_seq");
    check("latency_pp_from", 64'(pp_from), 64'd52);

    // Directed table from a fresh reset.
    vecs[0] = '{6'd12, 2'd0, 6'd0,  1'b1, 1'b0};
    vecs[1] = '{6'd36, 2'd0, 6'd0,  1'b1, 1'b0};
    vecs[2] = '{6'd52, 2'd1, 6'd52, 1'b1, 1'b1};
    vecs[3] = '{6'd35, 2'd0, 6'd0,  1'b1, 1'b1};
    vecs[4] = '{6'd52, 2'd2, 6'd52, 1'b1, 1'b0};
    vecs[5] = '{6'd52, 2'd1, 6'd52, 1'b1, 1'b1};
    vecs[6] = '{6'd36, 2'd2, 6'd36, 1'b0, 1'b0};
    vecs[7] = '{6'd52, 2'd0, 6'd0,  1'b0, 1'b0};
    vecs[8] = '{6'd12, 2'd1, 6'd12, 1'b0, 1'b1};
    vecs[9] = '{6'd28, 2'd2, 6'd28, 1'b1, 1'b0};

    reset_dut();
    for (int i = 0; i < 10; i++) begin
      do_click(vecs[i].sq);
      if (vecs[i].kind == 2'd1) exp_q.push_back({1'b0, vecs[i].pos});
      if (vecs[i].kind == 2'd2) exp_q.push_back({1'b1, vecs[i].pos});
      compare_events($sformatf("vec%0d", i));
      check($sformatf("vec%0d_turn", i), 64'(turn_white), 64'(vecs[i].turn));
      check($sformatf("vec%0d_held", i), 64'(piece_held), 64'(vecs[i].held));
      if (!vecs[i].held) check($sformatf("vec%0d_idle", i), 64'(dbg_state), 64'(IDLE));
    end

    // Random clicks against the reference model.
    reset_dut();
    for (int i = 0; i < 64; i++) board[i] = 4'($urandom_range(0, 13));
    for (int n = 0; n < 60; n++) begin
      if (!m_held) begin
        possible_moves = {$urandom, $urandom};
        sq = 6'($urandom_range(0, 63));
      end else begin
        lat = $urandom_range(0, 9);
        sq = 6'($urandom_range(0, 63));
        if (lat < 2) sq = m_from;
        else if (lat < 6) begin
          for (int k = 0; k < 64; k++) begin
            sq = 6'($urandom_range(0, 63));
            if (possible_moves[sq]) break;
          end
        end
      end
      model_click(sq);
      do_click(sq);
      compare_events($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d_turn", n), 64'(turn_white), 64'(m_turn));
      check($sformatf("rnd%0d_held", n), 64'(piece_held), 64'(m_held));
    end

    // Win while holding: everything afterwards is suppressed until reset.
    for (int i = 0; i < 64; i++) board[i] = EMPTY;
    board[52] = W_PAWN;
    possible_moves = 64'h0000_0010_1000_0000;
    reset_dut();
    do_click(52);
    exp_q.push_back({1'b0, 6'd52});
    compare_events("win_pick");
    white_win = 1'b1;
    repeat (3) @(negedge clk);
    check("win_game_over", 64'(game_over), 64'd1);
    check("win_state", 64'(dbg_state), 64'(OVER));
    do_click(36);
    do_click(52);
    white_win = 1'b0;
    black_win = 1'b1;
    do_click(52);
    black_win = 1'b0;
    do_click(36);
    compare_events("win_no_pulses");
    check("win_sticky", 64'(game_over), 64'd1);
    check("win_turn_kept", 64'(turn_white), 64'd1);
    reset_dut();
    check("win_cleared_by_reset", 64'(game_over), 64'd0);
    check("win_reset_state", 64'(dbg_state), 64'(IDLE));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
